// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin arbiter sharing one DMA controller among
// NUM_PORTS requesters. The winner's descriptor is latched, a one-cycle
// ctl_rqst is issued, and the data/ack handshake is routed to the winner
// until the controller's end flag.
// Optional watchdog abort: define DMA_ARB_WATCHDOG_EN.
module dma_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int ADD_LEN     = 16,
    parameter int DATA_LEN    = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             rqst,
    input  logic [NUM_PORTS-1:0]             rd_wr,
    input  logic [NUM_PORTS*ADD_LEN-1:0]     num_words,
    input  logic [NUM_PORTS*(ADD_LEN+1)-1:0] start_addr,
    input  logic [NUM_PORTS-1:0]             dev_ack,
    input  logic [NUM_PORTS*DATA_LEN-1:0]    dev_in,
    output logic [NUM_PORTS-1:0]             dma_ack,
    output logic [DATA_LEN-1:0]              dev_out,
    output logic [NUM_PORTS-1:0]             end_flag,
    output logic [NUM_PORTS-1:0]             err,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy,
    output logic                             ctl_rqst,
    output logic                             ctl_rd_wr,
    output logic                             ctl_dev_ack,
    output logic [ADD_LEN-1:0]               ctl_num_words,
    output logic [ADD_LEN:0]                 ctl_start_addr,
    output logic [DATA_LEN-1:0]              ctl_dev_in,
    input  logic                             ctl_dma_ack,
    input  logic                             ctl_end_flag,
    input  logic [DATA_LEN-1:0]              ctl_dev_out,
    output logic                             ctl_reset
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_ISSUE   = 3'd2,
        S_BUSY    = 3'd3,
`ifdef DMA_ARB_WATCHDOG_EN
        S_RELEASE = 3'd4,
        S_ABORT   = 3'd5
`else
        S_RELEASE = 3'd4
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        winner, last, pick;
    logic                 found;
    int                   idx;
    logic [NUM_PORTS-1:0] onehot;
    logic                 owned;

    logic                 d_rd_wr;
    logic [ADD_LEN-1:0]   d_num_words;
    logic [ADD_LEN:0]     d_start_addr;

`ifdef DMA_ARB_WATCHDOG_EN
    localparam int CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    logic [CW-1:0] wdog_cnt;
    logic          wdog_hit;

    // The counter is 0 on the first BUSY cycle; the limit is considered
    // reached on the cycle whose increment would make it WDOG_CYCLES-1,
    // which places ABORT WDOG_CYCLES cycles after ISSUE.
    assign wdog_hit = (wdog_cnt == CW'(WDOG_CYCLES - 2));

    // Watchdog counter: cleared in ISSUE, advancing every BUSY cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 wdog_cnt <= '0;
        else if (state == S_ISSUE) wdog_cnt <= '0;
        else if (state == S_BUSY)  wdog_cnt <= wdog_cnt + 1'b1;
    end
`endif

    // Round-robin search starting one past the last winner
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && rqst[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Winner, pointer and descriptor captured on the IDLE->GRANT edge so
    // they are already valid for the whole GRANT cycle; later device
    // changes are not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner       <= '0;
            last         <= PW'(NUM_PORTS - 1);
            d_rd_wr      <= 1'b0;
            d_num_words  <= '0;
            d_start_addr <= '0;
        end else if (state == S_IDLE && found) begin
            winner       <= pick;
            last         <= pick;
            d_rd_wr      <= rd_wr[pick];
            d_num_words  <= num_words[int'(pick)*ADD_LEN +: ADD_LEN];
            d_start_addr <= start_addr[int'(pick)*(ADD_LEN+1) +: ADD_LEN+1];
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (found) state_nxt = S_GRANT;
            S_GRANT:   state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_BUSY;
            S_BUSY: begin
                if (ctl_end_flag) state_nxt = S_RELEASE;
`ifdef DMA_ARB_WATCHDOG_EN
                else if (wdog_hit) state_nxt = S_ABORT;
`endif
            end
            S_RELEASE: state_nxt = S_IDLE;
`ifdef DMA_ARB_WATCHDOG_EN
            S_ABORT:   state_nxt = S_IDLE;
`endif
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output decode and handshake routing to the current owner
    always_comb begin
        onehot         = '0;
        onehot[winner] = 1'b1;
        owned          = (state == S_GRANT) || (state == S_ISSUE) ||
                         (state == S_BUSY)  || (state == S_RELEASE);
        busy           = (state != S_IDLE);
        grant          = busy ? onehot : '0;
        ctl_rqst       = (state == S_ISSUE);
        end_flag       = (state == S_RELEASE) ? onehot : '0;
        err            = '0;
        ctl_reset      = 1'b0;
`ifdef DMA_ARB_WATCHDOG_EN
        if (state == S_ABORT) begin
            end_flag  = onehot;
            err       = onehot;
            ctl_reset = 1'b1;
        end
`endif
        ctl_dev_ack = 1'b0;
        ctl_dev_in  = '0;
        dma_ack     = '0;
        if (owned) begin
            ctl_dev_ack = dev_ack[winner];
            ctl_dev_in  = dev_in[int'(winner)*DATA_LEN +: DATA_LEN];
            dma_ack     = ctl_dma_ack ? onehot : '0;
        end
    end

    assign dev_out        = ctl_dev_out;
    assign ctl_rd_wr      = d_rd_wr;
    assign ctl_num_words  = d_num_words;
    assign ctl_start_addr = d_start_addr;

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed test of dma_arbiter with hand-computed
// expectations; the bench plays the role of the DMA controller.
module tb_dma_arbiter;

    localparam int NP = 4;
    localparam int AL = 16;
    localparam int DL = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     rqst, rd_wr, dev_ack;
    logic [NP*AL-1:0]  num_words;
    logic [NP*(AL+1)-1:0] start_addr;
    logic [NP*DL-1:0]  dev_in;
    logic [NP-1:0]     dma_ack, end_flag, err, grant;
    logic [DL-1:0]     dev_out, ctl_dev_in, ctl_dev_out;
    logic              busy, ctl_rqst, ctl_rd_wr, ctl_dev_ack;
    logic [AL-1:0]     ctl_num_words;
    logic [AL:0]       ctl_start_addr;
    logic              ctl_dma_ack, ctl_end_flag, ctl_reset;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dma_arbiter #(
        .NUM_PORTS(NP), .ADD_LEN(AL), .DATA_LEN(DL)
`ifdef DMA_ARB_WATCHDOG_EN
        , .WDOG_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .reset(reset), .rqst(rqst), .rd_wr(rd_wr),
        .num_words(num_words), .start_addr(start_addr), .dev_ack(dev_ack),
        .dev_in(dev_in), .dma_ack(dma_ack), .dev_out(dev_out),
        .end_flag(end_flag), .err(err), .grant(grant), .busy(busy),
        .ctl_rqst(ctl_rqst), .ctl_rd_wr(ctl_rd_wr), .ctl_dev_ack(ctl_dev_ack),
        .ctl_num_words(ctl_num_words), .ctl_start_addr(ctl_start_addr),
        .ctl_dev_in(ctl_dev_in), .ctl_dma_ack(ctl_dma_ack),
        .ctl_end_flag(ctl_end_flag), .ctl_dev_out(ctl_dev_out),
        .ctl_reset(ctl_reset)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1 after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // full transfer starting from IDLE with the request already raised
    task automatic xfer(input string tag, input logic [NP-1:0] eg);
        tick();
        chk({tag, " grant"}, 32'(grant), 32'(eg));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, " ctl_rqst issue"}, 32'(ctl_rqst), 32'd1);
        tick();
        chk({tag, " ctl_rqst busy"}, 32'(ctl_rqst), 32'd0);
        tick();
        ctl_end_flag = 1'b1;
        tick();
        ctl_end_flag = 1'b0;
        chk({tag, " end_flag"}, 32'(end_flag), 32'(eg));
        tick();
        chk({tag, " end_flag clear"}, 32'(end_flag), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        rqst         = '0;
        rd_wr        = '0;
        dev_ack      = '0;
        num_words    = '0;
        start_addr   = '0;
        dev_in       = '0;
        ctl_dma_ack  = 1'b0;
        ctl_end_flag = 1'b0;
        ctl_dev_out  = '0;
        tick();
        tick();
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ctl_rqst", 32'(ctl_rqst), 32'd0);
        chk("rst end_flag", 32'(end_flag), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst ctl_reset", 32'(ctl_reset), 32'd0);
        chk("rst ctl_num_words", 32'(ctl_num_words), 32'd0);
        reset = 1'b0;
        tick();

        // single request from port 2
        rqst[2] = 1'b1;
        rd_wr[2] = 1'b1;
        num_words[2*AL +: AL] = 16'd4;
        start_addr[2*(AL+1) +: AL+1] = 17'h0200;
        tick();
        chk("single grant", 32'(grant), 32'b0100);
        chk("single ctl_rqst early", 32'(ctl_rqst), 32'd0);
        tick();
        rqst = '0;
        chk("single ctl_rqst", 32'(ctl_rqst), 32'd1);
        chk("single start_addr", 32'(ctl_start_addr), 32'h0200);
        chk("single num_words", 32'(ctl_num_words), 32'd4);
        chk("single rd_wr", 32'(ctl_rd_wr), 32'd1);
        tick();
        chk("single ctl_rqst pulse", 32'(ctl_rqst), 32'd0);
        tick();
        chk("single no end", 32'(end_flag), 32'd0);
        ctl_end_flag = 1'b1;
        tick();
        ctl_end_flag = 1'b0;
        chk("single end_flag", 32'(end_flag), 32'b0100);
        chk("single busy release", 32'(busy), 32'd1);
        tick();
        chk("single end_flag width", 32'(end_flag), 32'd0);
        chk("single grant clear", 32'(grant), 32'd0);

        // routing isolation: port 1 owns, port 0 toggles its handshake
        rqst = 4'b0010;
        tick();
        rqst = '0;
        chk("route grant", 32'(grant), 32'b0010);
        dev_ack = 4'b0011;
        dev_in[0 +: DL] = 16'hBEEF;
        dev_in[DL +: DL] = 16'h1234;
        ctl_dma_ack = 1'b1;
        ctl_dev_out = 16'hCAFE;
        #1;
        chk("route dev_ack", 32'(ctl_dev_ack), 32'd1);
        chk("route dev_in", 32'(ctl_dev_in), 32'h1234);
        chk("route dma_ack", 32'(dma_ack), 32'b0010);
        chk("route dev_out", 32'(dev_out), 32'hCAFE);
        dev_ack = 4'b0001;
        #1;
        chk("route dev_ack other", 32'(ctl_dev_ack), 32'd0);
        chk("route dev_in other", 32'(ctl_dev_in), 32'h1234);
        chk("route dma_ack0", 32'(dma_ack[0]), 32'd0);
        ctl_dma_ack = 1'b0;
        tick();
        tick();
        ctl_end_flag = 1'b1;
        tick();
        ctl_end_flag = 1'b0;
        chk("route end_flag", 32'(end_flag), 32'b0010);
        tick();
        ctl_dma_ack = 1'b1;
        dev_ack = 4'b0011;
        #1;
        chk("idle ctl_dev_ack", 32'(ctl_dev_ack), 32'd0);
        chk("idle ctl_dev_in", 32'(ctl_dev_in), 32'd0);
        chk("idle dma_ack", 32'(dma_ack), 32'd0);
        ctl_dma_ack = 1'b0;
        dev_ack = '0;

        // descriptor stability: port 3 changes num_words after grant
        num_words[3*AL +: AL] = 16'd8;
        rqst = 4'b1000;
        tick();
        chk("desc grant", 32'(grant), 32'b1000);
        chk("desc nw grant", 32'(ctl_num_words), 32'd8);
        num_words[3*AL +: AL] = 16'd2;
        rqst = '0;
        tick();
        chk("desc nw issue", 32'(ctl_num_words), 32'd8);
        tick();
        chk("desc nw busy", 32'(ctl_num_words), 32'd8);
        ctl_end_flag = 1'b1;
        tick();
        ctl_end_flag = 1'b0;
        chk("desc nw release", 32'(ctl_num_words), 32'd8);
        chk("desc end_flag", 32'(end_flag), 32'b1000);
        tick();

        // round-robin: ports 0,1,3 request continuously
        rqst = 4'b1011;
        xfer("rr0", 4'b0001);
        xfer("rr1", 4'b0010);
        xfer("rr2", 4'b1000);
        xfer("rr3", 4'b0001);
        xfer("rr4", 4'b0010);
        xfer("rr5", 4'b1000);

        // reset in BUSY
        rqst = 4'b0100;
        tick();
        chk("rmid grant", 32'(grant), 32'b0100);
        rqst = 4'b1111;
        tick();
        tick();
        chk("rmid busy state", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmid grant clr", 32'(grant), 32'd0);
        chk("rmid busy clr", 32'(busy), 32'd0);
        chk("rmid end_flag", 32'(end_flag), 32'd0);
        chk("rmid num_words", 32'(ctl_num_words), 32'd0);
        chk("rmid start_addr", 32'(ctl_start_addr), 32'd0);
        tick();
        reset = 1'b0;
        xfer("post rst", 4'b0001);
        rqst = '0;
        tick();

`ifdef DMA_ARB_WATCHDOG_EN
        // watchdog: the controller never ends
        rqst = 4'b0001;
        tick();
        rqst = '0;
        tick();
        chk("wdog issue", 32'(ctl_rqst), 32'd1);
        repeat (15) tick();
        chk("wdog not yet", 32'(ctl_reset), 32'd0);
        tick();
        chk("wdog ctl_reset", 32'(ctl_reset), 32'd1);
        chk("wdog err", 32'(err), 32'b0001);
        chk("wdog end_flag", 32'(end_flag), 32'b0001);
        tick();
        chk("wdog busy clr", 32'(busy), 32'd0);
        chk("wdog err clr", 32'(err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
